// File: rtl/rotate_pkg.sv
// Shared definitions for the multi-step rotate controller: state encoding,
// direction codes and default geometry.
package rotate_pkg;

    localparam int unsigned DEFAULT_WIDTH = 20;
    localparam int unsigned DEFAULT_AMT_W = 5;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rot1_stage.sv
// Purely combinational single-bit rotate. Left moves the MSB into bit 0,
// right moves bit 0 into the MSB.
module rot1_stage
    import rotate_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] data,
    input  logic             dir,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = data;
        if (dir == DIR_RIGHT) begin
            out = {data[0], data[WIDTH-1:1]};
        end else begin
            out = {data[WIDTH-2:0], data[WIDTH-1]};
        end
    end

endmodule

// File: rtl/rotate_sequencer.sv
// Multi-step rotate controller: accepts an operand over a valid/ready channel,
// applies one single-bit rotate per clock, and returns the result.
module rotate_sequencer
    import rotate_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned AMT_W = DEFAULT_AMT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic             req_dir,
    input  logic [AMT_W-1:0] req_amt,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             busy,
    output logic [AMT_W-1:0] steps_left
);

    localparam logic [AMT_W-1:0] WIDTH_A = AMT_W'(WIDTH);

    state_e           state_q;
    logic [WIDTH-1:0] data_q;
    logic             dir_q;
    logic [AMT_W-1:0] steps_q;
    logic [AMT_W-1:0] amt_mod;
    logic [WIDTH-1:0] rot_out;

    // One compare-and-subtract suffices when the amount range is below 2*WIDTH.
    if ((64'd1 << AMT_W) < 64'(2 * WIDTH)) begin : g_mod_sub
        assign amt_mod = (req_amt >= WIDTH_A) ? (req_amt - WIDTH_A) : req_amt;
    end else begin : g_mod_gen
        assign amt_mod = AMT_W'(32'(req_amt) % 32'(WIDTH));
    end

    rot1_stage #(
        .WIDTH (WIDTH)
    ) u_rot1 (
        .data (data_q),
        .dir  (dir_q),
        .out  (rot_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            dir_q   <= DIR_LEFT;
            steps_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        data_q  <= req_data;
                        dir_q   <= req_dir;
                        steps_q <= amt_mod;
                        state_q <= (amt_mod == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    data_q  <= rot_out;
                    steps_q <= steps_q - AMT_W'(1);
                    if (steps_q == AMT_W'(1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign resp_data  = data_q;
    assign steps_left = steps_q;

endmodule

// File: tb/tb_rotate_sequencer.sv
// Directed bench for rotate_sequencer: vector table for rotate results and
// latency, plus sequences for step count, backpressure and mid-run reset.
module tb_rotate_sequencer;

    localparam int unsigned WIDTH = 20;
    localparam int unsigned AMT_W = 5;
    localparam int          MAX_WAIT = 40;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_data;
    logic             req_dir;
    logic [AMT_W-1:0] req_amt;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_data;
    logic             busy;
    logic [AMT_W-1:0] steps_left;

    int total  = 0;
    int passed = 0;

    rotate_sequencer #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_dir    (req_dir),
        .req_amt    (req_amt),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy),
        .steps_left (steps_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             dir;
        logic [AMT_W-1:0] amt;
        logic [WIDTH-1:0] exp_data;
        int               exp_lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; caller guarantees the DUT is idle.
    task automatic send(input logic [WIDTH-1:0] d, input logic dir, input logic [AMT_W-1:0] amt);
        req_valid = 1'b1;
        req_data  = d;
        req_dir   = dir;
        req_amt   = amt;
        tick();
        req_valid = 1'b0;
    endtask

    // Called #1 after the accepting edge; latency counts that edge as 1.
    task automatic wait_resp(output int lat);
        lat = 1;
        while (!resp_valid && lat < MAX_WAIT) begin
            tick();
            lat++;
        end
    endtask

    task automatic take_resp();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic seen;

        vecs[0] = '{20'hAAAAA, 1'b0, 5'd1,  20'h55555, 2};
        vecs[1] = '{20'h00001, 1'b0, 5'd4,  20'h00010, 5};
        vecs[2] = '{20'h00001, 1'b1, 5'd1,  20'h80000, 2};
        vecs[3] = '{20'h00001, 1'b0, 5'd23, 20'h00008, 4};
        vecs[4] = '{20'h12345, 1'b0, 5'd0,  20'h12345, 1};
        vecs[5] = '{20'h12345, 1'b0, 5'd20, 20'h12345, 1};
        vecs[6] = '{20'h12345, 1'b1, 5'd4,  20'h51234, 5};
        vecs[7] = '{20'h80000, 1'b1, 5'd19, 20'h00001, 20};
        vecs[8] = '{20'hF0000, 1'b0, 5'd24, 20'h0000F, 5};

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_data   = '0;
        req_dir    = 1'b0;
        req_amt    = '0;
        resp_ready = 1'b0;
        tick();
        tick();
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset resp_data", 32'(resp_data), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset steps_left", 32'(steps_left), 32'd0);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            send(vecs[i].data, vecs[i].dir, vecs[i].amt);
            wait_resp(lat);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d resp_data", i), 32'(resp_data), 32'(vecs[i].exp_data));
            if (resp_valid) take_resp();
            check($sformatf("vec%0d back to idle", i), 32'(req_ready), 32'd1);
        end

        // Step counter across RUN; req_dir flipped after acceptance must not matter.
        send(20'h00001, 1'b0, 5'd4);
        req_dir = 1'b1;
        for (int k = 4; k >= 1; k--) begin
            check($sformatf("steps_left run k=%0d", k), 32'(steps_left), 32'(k));
            check($sformatf("busy run k=%0d", k), 32'(busy), 32'd1);
            tick();
        end
        check("steps_left done", 32'(steps_left), 32'd0);
        check("resp_valid after steps", 32'(resp_valid), 32'd1);
        check("dir latched data", 32'(resp_data), 32'h00010);
        take_resp();

        // Backpressure: hold DONE with a competing request pending.
        send(20'h00001, 1'b0, 5'd1);
        wait_resp(lat);
        check("bp latency", 32'(lat), 32'd2);
        req_valid = 1'b1;
        req_data  = 20'h00003;
        req_dir   = 1'b0;
        req_amt   = 5'd2;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("bp resp_valid c%0d", k), 32'(resp_valid), 32'd1);
            check($sformatf("bp resp_data c%0d", k), 32'(resp_data), 32'h00002);
            check($sformatf("bp req_ready c%0d", k), 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("bp idle req_ready", 32'(req_ready), 32'd1);
        check("bp idle resp_valid", 32'(resp_valid), 32'd0);
        check("bp idle busy", 32'(busy), 32'd0);
        tick();
        req_valid = 1'b0;
        check("bp accepted busy", 32'(busy), 32'd1);
        check("bp accepted steps", 32'(steps_left), 32'd2);
        wait_resp(lat);
        check("bp second latency", 32'(lat), 32'd3);
        check("bp second data", 32'(resp_data), 32'h0000C);
        if (resp_valid) take_resp();

        // Reset three cycles into RUN abandons the operation.
        send(20'h00001, 1'b0, 5'd10);
        tick();
        tick();
        tick();
        check("pre-reset busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        check("mid-run reset req_ready", 32'(req_ready), 32'd1);
        check("mid-run reset resp_valid", 32'(resp_valid), 32'd0);
        check("mid-run reset resp_data", 32'(resp_data), 32'd0);
        check("mid-run reset steps_left", 32'(steps_left), 32'd0);
        rst_n = 1'b1;
        resp_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (resp_valid) seen = 1'b1;
        end
        resp_ready = 1'b0;
        check("no response after reset", 32'(seen), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rotate_sequencer.md
# rotate_sequencer

Multi-step rotate controller for the ALU bit-shift group. It accepts one 20-bit operand, a direction and a rotate amount over a valid/ready request channel. It applies a single-bit rotate stage once per clock until the amount is used up, then returns the result over a valid/ready response channel. It sits between the ALU operation decoder and the result bus, and it is the only user of the 1-bit rotate stage.

## Interface
- WIDTH, 20: operand width in bits.
- AMT_W, 5: rotate-amount field width; must satisfy 2^AMT_W >= WIDTH.
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_data  input  WIDTH  operand.
- req_dir  input  1  0 = rotate left, 1 = rotate right.
- req_amt  input  AMT_W  rotate amount; reduced modulo WIDTH.
- resp_valid  output  1  result present.
- resp_ready  input  1  consumer takes result.
- resp_data  output  WIDTH  rotated operand.
- busy  output  1  high in RUN or DONE.
- steps_left  output  AMT_W  remaining single-bit rotations.

## Operation
- States:
  - IDLE: req_ready = 1.
  - RUN: rotating.
  - DONE: resp_valid = 1.
- Accept: a handshake occurs when req_valid && req_ready at a rising edge. On acceptance:
  - The data register loads req_data and the direction register loads req_dir.
  - steps_left loads n = req_amt mod WIDTH (for AMT_W=5, WIDTH=20: 20..31 map to 0..11).
  - Next state is DONE if n == 0, else RUN.
- RUN, each cycle:
  - Data register <= rot1(data, dir), where left moves bit WIDTH-1 to bit 0 and right moves bit 0 to bit WIDTH-1.
  - steps_left decrements by 1.
  - When steps_left == 1, next state is DONE.
- DONE:
  - resp_data = data register, held stable while resp_valid && !resp_ready.
  - On resp_ready the state returns to IDLE.
- No request is accepted outside IDLE; req_ready is low in RUN and DONE, so there is no skid.
- Request inputs are ignored except in IDLE.
- Direction is latched at acceptance; changes on req_dir mid-operation have no effect.

## Timing
- Reset values:
  - state = IDLE, data register = 0, direction register = 0, steps_left = 0.
  - req_ready = 1, resp_valid = 0, resp_data = 0, busy = 0.
- Reset mid-RUN or mid-DONE abandons the operation. The first cycle after reset is IDLE, and no response is produced for the abandoned request.
- Latency: resp_valid is first high n+1 cycles after the accepting edge's cycle.
  - n = 0: resp_valid is high in the cycle immediately after acceptance.
  - n = k: resp_valid is high k cycles later than the n = 0 case.
- Throughput: one request per n+2 cycles minimum. DONE→IDLE takes one cycle, because req_ready is not high in the DONE cycle.
- All outputs are registered or decoded from state only; there is no combinational path from request inputs to outputs.
- resp_data is valid only while resp_valid is high, and equals the data register in every state.

## Structure
- Shared package rotate_pkg, holding:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - direction constants DIR_LEFT=1'b0 and DIR_RIGHT=1'b1;
  - default WIDTH=20 and AMT_W=5.
- Sub-module rot1_stage: purely combinational single-bit rotate (data, dir → out), instantiated once.
- Top level contains:
  - the FSM;
  - the modulo reduction of req_amt (a single compare-and-subtract when 2^AMT_W < 2·WIDTH, otherwise a general modulo);
  - the step counter;
  - the data register.

## Test plan
- Left rotate: 20'hAAAAA, dir 0, amt 1 → resp_data 20'h55555, resp_valid 2 cycles after acceptance.
- Multi-step left: 20'h00001, dir 0, amt 4 → 20'h00010; steps_left reads 4,3,2,1,0 across RUN; latency 5.
- Right rotate with wrap: 20'h00001, dir 1, amt 1 → 20'h80000. Modulo case: 20'h00001, dir 0, amt 23 → 20'h00008, latency 4.
- Zero amount: 20'h12345, amt 0 and separately amt 20 → 20'h12345, resp_valid the cycle after acceptance, RUN never entered.
- Backpressure: hold resp_ready low 3 cycles in DONE → resp_valid and resp_data stable, req_ready 0, a new req_valid is not accepted; it is accepted in IDLE one cycle after resp_ready rises.
- Reset mid-RUN: 20'h00001, amt 10, assert rst_n=0 after 3 RUN cycles → next cycle IDLE, req_ready 1, resp_valid 0, resp_data 0, no response ever issued.
